// File: rtl/cmd_tx.sv
// Response framer for the FT245 link: SYNC, TAG, [SEQ], LEN, payload, CRC-8.
// Define CMD_TX_SEQ_EN to insert an 8-bit frame sequence byte after TAG.
module cmd_tx #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter logic [7:0] CRC_POLY  = 8'h07,
  parameter logic [7:0] CRC_INIT  = 8'h00
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic [7:0] i_req_tag,
  input  logic [7:0] i_req_len,
  input  logic [7:0] i_pl_data,
  input  logic       i_pl_valid,
  output logic       o_pl_ready,
  output logic [7:0] o_st_data,
  output logic       o_st_valid,
  input  logic       i_st_ready
);

  // Each state names the byte it loads next; SYNC is loaded on acceptance in IDLE.
  typedef enum logic [2:0] {
    S_IDLE,
    S_TAG,
    S_SEQ,
    S_LEN,
    S_PAYLOAD,
    S_CRC
  } state_t;

  state_t     state, state_nx;
  logic [7:0] tag_q, len_q, cnt_q, crc_q;
  logic       slot_free;
  logic       load;
  logic [7:0] load_byte;
  logic       crc_en;
  logic       accept;
  logic       cnt_ld, cnt_dec;
  logic       req_rdy, pl_rdy;
`ifdef CMD_TX_SEQ_EN
  logic [7:0] seq_q;
  logic       seq_inc;
`endif

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c ^ b;
    for (int unsigned i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ CRC_POLY) : (r << 1);
    end
    return r;
  endfunction

  assign slot_free   = !o_st_valid || i_st_ready;
  assign o_req_ready = i_rst_n && req_rdy;
  assign o_pl_ready  = i_rst_n && pl_rdy;

  always_comb begin
    state_nx  = state;
    load      = 1'b0;
    load_byte = '0;
    crc_en    = 1'b0;
    accept    = 1'b0;
    cnt_ld    = 1'b0;
    cnt_dec   = 1'b0;
    req_rdy   = 1'b0;
    pl_rdy    = 1'b0;
`ifdef CMD_TX_SEQ_EN
    seq_inc   = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        req_rdy = slot_free;
        if (i_req_valid && slot_free) begin
          accept    = 1'b1;
          load      = 1'b1;
          load_byte = SYNC_BYTE;
          state_nx  = S_TAG;
        end
      end
      S_TAG: begin
        if (slot_free) begin
          load      = 1'b1;
          load_byte = tag_q;
          crc_en    = 1'b1;
`ifdef CMD_TX_SEQ_EN
          state_nx  = S_SEQ;
`else
          state_nx  = S_LEN;
`endif
        end
      end
`ifdef CMD_TX_SEQ_EN
      S_SEQ: begin
        if (slot_free) begin
          load      = 1'b1;
          load_byte = seq_q;
          crc_en    = 1'b1;
          state_nx  = S_LEN;
        end
      end
`endif
      S_LEN: begin
        if (slot_free) begin
          load      = 1'b1;
          load_byte = len_q;
          crc_en    = 1'b1;
          cnt_ld    = 1'b1;
          state_nx  = (len_q == 8'd0) ? S_CRC : S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        pl_rdy = slot_free;
        if (i_pl_valid && slot_free) begin
          load      = 1'b1;
          load_byte = i_pl_data;
          crc_en    = 1'b1;
          cnt_dec   = 1'b1;
          if (cnt_q == 8'd1) state_nx = S_CRC;
        end
      end
      S_CRC: begin
        if (slot_free) begin
          load      = 1'b1;
          load_byte = crc_q;
          state_nx  = S_IDLE;
`ifdef CMD_TX_SEQ_EN
          seq_inc   = 1'b1;
`endif
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      o_st_valid <= 1'b0;
      o_st_data  <= '0;
      crc_q      <= CRC_INIT;
      tag_q      <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state <= state_nx;
      if (load) begin
        o_st_data  <= load_byte;
        o_st_valid <= 1'b1;
      end else if (i_st_ready) begin
        o_st_valid <= 1'b0;
      end
      if (accept) begin
        tag_q <= i_req_tag;
        len_q <= i_req_len;
        crc_q <= CRC_INIT;
      end else if (crc_en) begin
        crc_q <= crc_step(crc_q, load_byte);
      end
      if (cnt_ld) cnt_q <= len_q;
      else if (cnt_dec) cnt_q <= cnt_q - 8'd1;
    end
  end

`ifdef CMD_TX_SEQ_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) seq_q <= '0;
    else if (seq_inc) seq_q <= seq_q + 8'd1;
  end
`endif

endmodule
